aexm_xseq: RTL and testbench



---
 rtl/aexm_xseq.sv | 141 ++++++++++++++
 tb/tb_aexm_xseq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/aexm_xseq.sv
// Execute-stage sequencer: paces result capture for single-cycle, multiply/barrel-shift and data-cache ops.
// Optional build macro AEXM_XSEQ_TMO_EN adds the data-cache wait timeout (tmo counter, o_dc_err pulse).
module aexm_xseq #(
  parameter int MUL     = 0,
  parameter int BSF     = 0,
  parameter int MUL_LAT = 2,
  parameter int BSF_LAT = 2,
  parameter int DC_TMO  = 255
) (
  input  logic       gclk,
  input  logic       grst,
  input  logic       i_vld,
  input  logic       xSKIP,
  input  logic [2:0] rMXALU,
  input  logic       i_mem,
  input  logic       dc_ack,
  output logic       x_en,
  output logic       fSTALL,
  output logic       o_busy,
  output logic       o_dc_req,
  output logic       o_dc_err,
  output logic       o_ill
);

  typedef enum logic [1:0] {IDLE = 2'd0, OPER = 2'd1, MEMW = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       x_en_s, fstall_s, busy_s, dc_req_s, dc_err_s, ill_s;
`ifdef AEXM_XSEQ_TMO_EN
  logic [7:0] tmo_q, tmo_d;
`endif

  // State, latency counter and timeout counter registers.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
`ifdef AEXM_XSEQ_TMO_EN
      tmo_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef AEXM_XSEQ_TMO_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state and Mealy output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
`ifdef AEXM_XSEQ_TMO_EN
    tmo_d    = tmo_q;
`endif
    x_en_s   = 1'b0;
    fstall_s = 1'b0;
    busy_s   = 1'b0;
    dc_req_s = 1'b0;
    dc_err_s = 1'b0;
    ill_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_vld) begin
          if (xSKIP) begin
            x_en_s = 1'b1;
          end else if (i_mem) begin
            dc_req_s = 1'b1;
            busy_s   = 1'b1;
`ifdef AEXM_XSEQ_TMO_EN
            tmo_d    = 8'd1;
`endif
            state_d  = MEMW;
          end else if (rMXALU == 3'd4 && MUL != 0) begin
            fstall_s = 1'b1;
            busy_s   = 1'b1;
            cnt_d    = 4'(MUL_LAT - 2);
            state_d  = OPER;
          end else if (rMXALU == 3'd5 && BSF != 0) begin
            fstall_s = 1'b1;
            busy_s   = 1'b1;
            cnt_d    = 4'(BSF_LAT - 2);
            state_d  = OPER;
          end else if (rMXALU <= 3'd3) begin
            x_en_s = 1'b1;
          end else begin
            // Reserved codes and absent units still retire so issue never deadlocks.
            x_en_s = 1'b1;
            ill_s  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OPER: begin
        fstall_s = 1'b1;
        if (cnt_q == 4'd0) begin
          x_en_s  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_s = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      MEMW: begin
        dc_req_s = 1'b1;
        if (dc_ack) begin
          x_en_s  = 1'b1;
          state_d = IDLE;
`ifdef AEXM_XSEQ_TMO_EN
        end else if (tmo_q == 8'(DC_TMO)) begin
          x_en_s   = 1'b1;
          dc_err_s = 1'b1;
          state_d  = IDLE;
        end else begin
          busy_s = 1'b1;
          tmo_d  = tmo_q + 8'd1;
`else
        end else begin
          busy_s = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just at the next edge.
  assign x_en     = grst & x_en_s;
  assign fSTALL   = grst & fstall_s;
  assign o_busy   = grst & busy_s;
  assign o_dc_req = grst & dc_req_s;
  assign o_dc_err = grst & dc_err_s;
  assign o_ill    = grst & ill_s;

endmodule

// File: tb/tb_aexm_xseq.sv
// Randomized and directed bench for aexm_xseq: two instances (units on / units off) against a transaction-age model.
module tb_aexm_xseq;

  localparam int LAT_MUL = 4;
  localparam int LAT_BSF = 4;
  localparam int TMO_LIM = 3;

  logic       gclk = 1'b0;
  logic       grst;
  logic       i_vld, xSKIP, i_mem, dc_ack;
  logic [2:0] rMXALU;
  logic [5:0] outs [2];

  logic a_x, a_f, a_b, a_r, a_e, a_i;
  logic b_x, b_f, b_b, b_r, b_e, b_i;

  int errs = 0;
  int checks = 0;

  // Model per instance: kind 0 idle, 1 multi-cycle op, 2 memory wait; age = cycles since accept.
  int kind_m [2];
  int age_m  [2];
  int lat_m  [2];
  bit mul_en [2] = '{1'b1, 1'b0};
  bit bsf_en [2] = '{1'b1, 1'b0};

  always #5 gclk = ~gclk;

  aexm_xseq #(.MUL(1), .BSF(1), .MUL_LAT(LAT_MUL), .BSF_LAT(LAT_BSF), .DC_TMO(TMO_LIM)) dut_a (
    .gclk(gclk), .grst(grst), .i_vld(i_vld), .xSKIP(xSKIP), .rMXALU(rMXALU), .i_mem(i_mem),
    .dc_ack(dc_ack), .x_en(a_x), .fSTALL(a_f), .o_busy(a_b), .o_dc_req(a_r), .o_dc_err(a_e), .o_ill(a_i));

  aexm_xseq #(.MUL(0), .BSF(0), .MUL_LAT(2), .BSF_LAT(2), .DC_TMO(TMO_LIM)) dut_b (
    .gclk(gclk), .grst(grst), .i_vld(i_vld), .xSKIP(xSKIP), .rMXALU(rMXALU), .i_mem(i_mem),
    .dc_ack(dc_ack), .x_en(b_x), .fSTALL(b_f), .o_busy(b_b), .o_dc_req(b_r), .o_dc_err(b_e), .o_ill(b_i));

  assign outs[0] = {a_x, a_f, a_b, a_r, a_e, a_i};
  assign outs[1] = {b_x, b_f, b_b, b_r, b_e, b_i};

`ifdef AEXM_XSEQ_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s t=%0t got {x_en,fSTALL,busy,req,err,ill}=%b expected %b", tag, $time, obs, exp_v);
    end
  endtask

  // Expected {x_en,fSTALL,o_busy,o_dc_req,o_dc_err,o_ill} for the current cycle.
  function automatic logic [5:0] exp_out(input int n);
    logic [5:0] e;
    e = 6'b0;
    if (grst) begin
      if (kind_m[n] == 0) begin
        if (i_vld) begin
          if (xSKIP) e = 6'b100000;
          else if (i_mem) e = 6'b001100;
          else if ((rMXALU == 3'd4 && mul_en[n]) || (rMXALU == 3'd5 && bsf_en[n])) e = 6'b011000;
          else if (rMXALU < 3'd4) e = 6'b100000;
          else e = 6'b100001;
        end
      end else if (kind_m[n] == 1) begin
        e = (age_m[n] == lat_m[n] - 1) ? 6'b110000 : 6'b011000;
      end else begin
        if (dc_ack) e = 6'b100100;
        else if (TMO_ON && age_m[n] == TMO_LIM) e = 6'b100110;
        else e = 6'b001100;
      end
    end
    return e;
  endfunction

  task automatic step_model(input int n);
    if (!grst) begin
      kind_m[n] = 0;
    end else if (kind_m[n] == 0) begin
      if (i_vld && !xSKIP) begin
        if (i_mem) begin
          kind_m[n] = 2; age_m[n] = 1;
        end else if (rMXALU == 3'd4 && mul_en[n]) begin
          kind_m[n] = 1; age_m[n] = 1; lat_m[n] = LAT_MUL;
        end else if (rMXALU == 3'd5 && bsf_en[n]) begin
          kind_m[n] = 1; age_m[n] = 1; lat_m[n] = LAT_BSF;
        end
      end
    end else if (kind_m[n] == 1) begin
      if (age_m[n] == lat_m[n] - 1) kind_m[n] = 0;
      else age_m[n]++;
    end else begin
      if (dc_ack || (TMO_ON && age_m[n] == TMO_LIM)) kind_m[n] = 0;
      else age_m[n]++;
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge gclk);
    check_val({tag, "_a"}, outs[0], exp_out(0));
    check_val({tag, "_b"}, outs[1], exp_out(1));
    @(posedge gclk);
    step_model(0);
    step_model(1);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [2:0] alu, input logic m, input logic a);
    i_vld = v; xSKIP = s; rMXALU = alu; i_mem = m; dc_ack = a;
  endtask

  initial begin
    kind_m = '{0, 0};
    age_m  = '{0, 0};
    lat_m  = '{2, 2};
    grst = 1'b0;
    drive(1'b1, 1'b0, 3'd4, 1'b0, 1'b1);
    cycle("reset");
    cycle("reset");
    @(posedge gclk); #1;
    grst = 1'b1;

    // Add then logic back to back.
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0); cycle("add");
    drive(1'b1, 1'b0, 3'd1, 1'b0, 1'b0); cycle("logic");
    // Multiply: four cycles on the unit-equipped instance, illegal on the other.
    drive(1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < LAT_MUL; i++) cycle("mul");
    // Load with ack five cycles after accept.
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      dc_ack = (i == 5) ? 1'b1 : 1'b0;
      if (kind_m[0] == 0 && i > 0) i_vld = 1'b0;
      cycle("load");
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0); cycle("idle");
    // Load with ack exactly at the timeout cycle.
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dc_ack = (i == 3) ? 1'b1 : 1'b0;
      cycle("ack_tmo");
      if (kind_m[0] == 0) i_vld = 1'b0;
    end
    // Skipped load and skipped multiply retire immediately.
    drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b0); cycle("skip_ld");
    drive(1'b1, 1'b1, 3'd4, 1'b0, 1'b0); cycle("skip_mul");
    // Barrel shift, reset in its second cycle, then a fresh add.
    drive(1'b1, 1'b0, 3'd5, 1'b0, 1'b0); cycle("bsf");
    grst = 1'b0;
    #2;
    check_val("rst_async_a", outs[0], 6'b0);
    check_val("rst_async_b", outs[1], 6'b0);
    cycle("rst_hold");
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    grst = 1'b1;
    cycle("post_rst_add");

    // Random traffic; instruction inputs held while either instance is mid-instruction.
    for (int c = 0; c < 3000; c++) begin
      if (kind_m[0] == 0 && kind_m[1] == 0) begin
        i_vld  = ($urandom_range(0, 3) != 0);
        rMXALU = 3'($urandom_range(0, 7));
        i_mem  = ($urandom_range(0, 4) == 0);
      end
      xSKIP  = ($urandom_range(0, 7) == 0);
      dc_ack = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
